// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program sequencer feeding the ALU decoder
// Steps a small writable opcode program, honouring repeat counts and downstream stalls.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          alu_busy,
  output logic [2:0]    address,
  output logic          issue,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  word;
  logic [3:0]  rep;
  logic        fire;
  logic        at_end;

  assign at_end = (pc == AW'(DEPTH - 1));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // fire marks an unstalled ISSUE cycle; it alone produces an issue strobe next cycle
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (!alu_busy) begin
          fire = 1'b1;
          if (rep != 4'd0)      state_next = ISSUE;
          else if (word[7])     state_next = DONE;
          else if (at_end)      state_next = DONE;
          else                  state_next = FETCH;
        end
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Program memory is deliberately not reset; it is only writable while idle
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      address <= 3'd0;
      issue   <= 1'b0;
      overrun <= 1'b0;
      rep     <= 4'd0;
      word    <= 8'd0;
    end else begin
      issue <= fire;
      if (fire) address <= word[2:0];
      case (state)
        IDLE: begin
          if (start) begin
            pc      <= '0;
            overrun <= 1'b0;
          end
        end
        FETCH: begin
          word <= mem[pc];
          rep  <= mem[pc][6:3];
        end
        ISSUE: begin
          if (fire) begin
            if (rep != 4'd0) begin
              rep <= rep - 4'd1;
            end else if (!word[7]) begin
              // pc never wraps: running off the end is flagged instead
              if (at_end) overrun <= 1'b1;
              else        pc      <= pc + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;

  typedef struct packed {
    logic [7:0] cyc;
    logic [2:0] a;
    logic       d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, start, prog_we, alu_busy;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] address;
  logic       issue, busy, done, overrun;
  logic [3:0] pc;

  int checks = 0;
  int fails  = 0;
  int done_cnt, done_cyc;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic busy_log [0:63];
  logic issue_log[0:63];
  logic ovr_log  [0:63];
  logic [3:0] pc_log  [0:63];
  logic [2:0] addr_log[0:63];

  alu_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .alu_busy(alu_busy),
    .address(address), .issue(issue), .pc(pc), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic write_word(input int a, input int d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = 8'(d);
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic push_exp(input int c, input int a, input bit d);
    ev_t e;
    e.cyc = 8'(c); e.a = 3'(a); e.d = d;
    exp_q.push_back(e);
  endtask

  // start is high in cycle 0; outputs of cycle c are sampled at its negedge
  task automatic run(input int n, input int stall_lo, input int stall_hi,
                     input int junk_lo, input int junk_hi, input int rst_cyc);
    ev_t o;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0; reset = 1'b0;
      busy_log[c] = busy; issue_log[c] = issue; ovr_log[c] = overrun;
      pc_log[c] = pc; addr_log[c] = address;
      if (issue) begin
        o.cyc = 8'(c); o.a = address; o.d = done;
        obs_q.push_back(o);
      end
      if (done) begin done_cnt++; done_cyc = c; end
      alu_busy = (c >= stall_lo && c <= stall_hi);
      if (c >= junk_lo && c <= junk_hi) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h86;
      end
      if (c == rst_cyc) reset = 1'b1;
    end
    alu_busy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; alu_busy = 1'b0;
    prog_addr = 4'd0; prog_data = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (address !== 3'd0) begin fails++; $display("FAIL reset_address got %0d want 0", address); end
    checks++; if (issue !== 1'b0)   begin fails++; $display("FAIL reset_issue got %b want 0", issue); end
    checks++; if (pc !== 4'd0)      begin fails++; $display("FAIL reset_pc got %0d want 0", pc); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_single;
    ev_t e, o;
    write_word(0, 8'h85);
    push_exp(3, 5, 1'b1);
    run(6, -1, -1, -1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL single_issue missing cyc %0d op %0d", e.cyc, e.a); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL single_issue got cyc %0d op %0d done %b want cyc %0d op %0d done %b", o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
      end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL single_extra got %0d extra issues want 0", obs_q.size()); end
    checks++; if (done_cnt != 1 || done_cyc != 3) begin fails++; $display("FAIL single_done got %0d pulses last cyc %0d want 1 at 3", done_cnt, done_cyc); end
    checks++; if (busy_log[3] !== 1'b1 || busy_log[4] !== 1'b0) begin fails++; $display("FAIL single_busy got %b%b want 10", busy_log[3], busy_log[4]); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL single_overrun got %b want 0", overrun); end
  endtask

  task automatic test_repeat;
    ev_t e, o;
    write_word(0, 8'h10);
    write_word(1, 8'h83);
    push_exp(3, 0, 1'b0); push_exp(4, 0, 1'b0); push_exp(5, 0, 1'b0);
    push_exp(7, 3, 1'b1);
    run(10, -1, -1, -1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL repeat_issue missing cyc %0d op %0d", e.cyc, e.a); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL repeat_issue got cyc %0d op %0d done %b want cyc %0d op %0d done %b", o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
      end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL repeat_extra got %0d extra issues want 0", obs_q.size()); end
    checks++; if (issue_log[6] !== 1'b0) begin fails++; $display("FAIL repeat_bubble got %b want 0", issue_log[6]); end
  endtask

  task automatic test_stall;
    ev_t e, o;
    write_word(0, 8'h9A);
    for (int c = 5; c <= 8; c++) push_exp(c, 2, c == 8);
    run(11, 2, 3, -1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL stall_issue missing cyc %0d op %0d", e.cyc, e.a); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL stall_issue got cyc %0d op %0d done %b want cyc %0d op %0d done %b", o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
      end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL stall_extra got %0d extra issues want 0", obs_q.size()); end
    checks++; if (done_cnt != 1 || done_cyc != 8) begin fails++; $display("FAIL stall_done got %0d pulses last cyc %0d want 1 at 8", done_cnt, done_cyc); end
  endtask

  task automatic test_overrun;
    ev_t e, o;
    for (int i = 0; i < 16; i++) write_word(i, 8'h07);
    for (int k = 0; k < 16; k++) push_exp(3 + 2 * k, 7, k == 15);
    run(37, -1, -1, -1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL overrun_issue missing cyc %0d op %0d", e.cyc, e.a); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL overrun_issue got cyc %0d op %0d done %b want cyc %0d op %0d done %b", o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
      end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL overrun_extra got %0d extra issues want 0", obs_q.size()); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++; if (pc !== 4'd15)     begin fails++; $display("FAIL overrun_pc got %0d want 15", pc); end
    checks++; if (done_cnt != 1 || done_cyc != 33) begin fails++; $display("FAIL overrun_done got %0d pulses last cyc %0d want 1 at 33", done_cnt, done_cyc); end
    write_word(0, 8'h85);
    run(6, -1, -1, -1, -1, -1);
    checks++; if (ovr_log[1] !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got %b/%b want 0/0", ovr_log[1], overrun); end
  endtask

  task automatic test_busy_ignore;
    ev_t e, o;
    write_word(0, 8'h1C);
    write_word(1, 8'h81);
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 3; c <= 6; c++) push_exp(c, 4, 1'b0);
      push_exp(8, 1, 1'b1);
      if (pass == 0) run(12, -1, -1, 2, 4, -1);
      else           run(12, -1, -1, -1, -1, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (obs_q.size() == 0) begin fails++; $display("FAIL ignore_issue pass %0d missing cyc %0d op %0d", pass, e.cyc, e.a); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin fails++; $display("FAIL ignore_issue pass %0d got cyc %0d op %0d done %b want cyc %0d op %0d done %b", pass, o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
        end
      end
      checks++; if (obs_q.size() != 0 || done_cnt != 1) begin fails++; $display("FAIL ignore_extra pass %0d got %0d extra issues %0d dones want 0 and 1", pass, obs_q.size(), done_cnt); end
    end
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    write_word(0, 8'h9A);
    push_exp(3, 2, 1'b0);
    run(8, -1, -1, -1, -1, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL midreset_issue missing cyc %0d op %0d", e.cyc, e.a); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL midreset_issue got cyc %0d op %0d done %b want cyc %0d op %0d done %b", o.cyc, o.a, o.d, e.cyc, e.a, e.d); end
      end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL midreset_extra got %0d extra issues want 0", obs_q.size()); end
    checks++; if (issue_log[4] !== 1'b0 || busy_log[4] !== 1'b0) begin fails++; $display("FAIL midreset_state got issue %b busy %b want 0 0", issue_log[4], busy_log[4]); end
    checks++; if (pc_log[4] !== 4'd0 || addr_log[4] !== 3'd0) begin fails++; $display("FAIL midreset_regs got pc %0d addr %0d want 0 0", pc_log[4], addr_log[4]); end
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL midreset_done got %0d pulses want 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_stall();
    test_overrun();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer that sits directly upstream of the ALU decoder. It holds a small writable program of opcode words. On `start` it steps through them, presenting one 3-bit opcode on `address` per issue slot, with a one-cycle `issue` strobe. It honours per-word repeat counts, stalls on `alu_busy` from the datapath, and stops on the word marked last or at the end of memory.

## Interface
Parameters:
- DEPTH, 16, number of program words
- AW, 4, program address width (DEPTH = 2^AW)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution at word 0; sampled only in IDLE
- prog_we  in  1  program write enable; honoured only in IDLE
- prog_addr  in  AW  program write address
- prog_data  in  8  program word: bit7 last, bits6:3 repeat, bits2:0 opcode
- alu_busy  in  1  downstream stall; no issue in a cycle where it is high
- address  out  3  opcode to decoder; registered, holds last issued value
- issue  out  1  one-cycle strobe, high in the cycle `address` is new
- pc  out  AW  index of word currently executing
- busy  out  1  high whenever state is not IDLE
- done  out  1  high for exactly one cycle (DONE state)
- overrun  out  1  sticky: program ended at word DEPTH-1 without last bit

## Operation
- Memory: DEPTH x 8 register array, write-synchronous, not reset (contents undefined until written).
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - prog_we writes mem[prog_addr] <= prog_data.
  - start: pc <= 0, overrun <= 0, go to FETCH.
- Write and start in the same IDLE cycle: both take effect; FETCH sees the written data.
- FETCH: word <= mem[pc]; rep <= mem[pc][6:3]; go to ISSUE.
- ISSUE, alu_busy high: hold all registers and state; issue <= 0.
- ISSUE, alu_busy low: address <= word[2:0], issue <= 1. Then:
  - rep != 0: rep <= rep-1, stay in ISSUE.
  - rep == 0 and word[7]=1: go to DONE.
  - rep == 0, word[7]=0, pc == DEPTH-1: overrun <= 1, go to DONE.
  - otherwise: pc <= pc+1, go to FETCH.
- Each word therefore issues rep+1 times (1..16). pc never wraps.
- DONE: done=1 (Moore output); go to IDLE.
- issue is 0 in every cycle not directly following an unstalled ISSUE cycle.
- start while busy: ignored. prog_we while busy: ignored, memory unchanged.
- Reset, including mid-run: state IDLE, pc=0, address=0, issue=0, overrun=0, rep=0, word=0. No done pulse is produced.

## Timing
- start high in cycle 0 -> FETCH in cycle 1 -> ISSUE in cycle 2 -> first issue=1 in cycle 3.
- Back-to-back issues within one word: one per cycle while alu_busy is low.
- Word boundary: one FETCH bubble, so issue=0 for one cycle between words.
- Last issue of the program coincides with done=1. busy falls the following cycle.
- alu_busy is sampled in ISSUE only; a stall adds exactly one cycle per high cycle.

## Test plan
- Write mem[0]=0x85 (last, rep 0, op 5); pulse start -> issue=1 with address=5 in cycle 3, done=1 in cycle 3, busy=0 in cycle 4, overrun=0.
- mem[0]=0x10 (rep 2, op 0), mem[1]=0x83 -> address 0,0,0 in cycles 3-5, bubble in cycle 6, address 3 in cycle 7 with done=1.
- mem[0]=0x9A (last, rep 3, op 2); alu_busy high in cycles 2-3 -> issues in cycles 5,6,7,8 with address=2; done in cycle 8.
- All 16 words=0x07 (no last) -> 16 issues of op 7, overrun=1, done pulses, pc=15; next start clears overrun.
- Start while busy and prog_we while busy -> no restart, memory unchanged (verify by rerun); reset asserted mid-ISSUE -> next cycle issue=0, busy=0, pc=0, no done.
